// File: rtl/batch_reverse_buffer.sv
// batch_reverse_buffer
//   Buffers an input sample stream in batches of `batch` samples and replays
//   each completed batch in reverse order, one sample per accepted input.
//   Two banks operate as a ping-pong pair. One bank is written in forward
//   order while the other, already complete, is read back newest-first.
//
// Ports
//   clk        clock; all state updates happen on posedge
//   rst_n      asynchronous active-low reset
//   clr        synchronous flush; same effect as reset, wins over in_valid
//   in         input sample in forward time order
//   in_valid   input sample accepted this cycle (no back-pressure)
//   out        reversed sample (registered)
//   out_valid  out holds a valid sample this cycle
//   out_first  out is the newest sample of its batch
//   out_last   out is the oldest sample of its batch
module batch_reverse_buffer #(
  parameter int size  = 4,
  parameter int batch = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic [size-1:0] in,
  input  logic            in_valid,
  output logic [size-1:0] out,
  output logic            out_valid,
  output logic            out_first,
  output logic            out_last
);

  localparam int IDX_W  = $clog2(batch);
  localparam int ADDR_W = $clog2(2 * batch);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(batch - 1);
  localparam logic [ADDR_W-1:0] BANK_SPAN  = ADDR_W'(batch);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bank b occupies entries [b*batch, b*batch + batch - 1].
  logic [size-1:0] mem [2*batch];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             wr_bank_q, wr_bank_d;
  logic [size-1:0]  out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             out_first_q, out_first_d;
  logic             out_last_q, out_last_d;

  logic              wr_en;
  logic              rd_bank;
  logic [IDX_W-1:0]  rd_idx;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [size-1:0]   rd_data;

  // The read always targets the bank opposite the one being written, using
  // the pre-update wr_bank. On the wrap cycle that is still the older bank.
  // From the next accepted sample on, it is the bank just completed.
  always_comb begin
    wr_en   = in_valid && !clr;
    rd_bank = ~wr_bank_q;
    rd_idx  = LAST_IDX - wr_idx_q;
    wr_addr = (wr_bank_q ? BANK_SPAN : '0) + ADDR_W'(wr_idx_q);
    rd_addr = (rd_bank   ? BANK_SPAN : '0) + ADDR_W'(rd_idx);
    rd_data = mem[rd_addr];
  end

  // Storage carries no reset. Stale contents are never observed, because
  // output only starts after a complete new batch has been written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= in;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    wr_bank_d   = wr_bank_q;
    out_d       = out_q;        // out holds its value across gaps
    out_valid_d = 1'b0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;

    if (clr) begin
      state_d   = FILL;
      wr_idx_d  = '0;
      wr_bank_d = 1'b0;
      out_d     = '0;
    end else if (in_valid) begin
      if (state_q == RUN) begin
        out_d       = rd_data;
        out_valid_d = 1'b1;
        out_first_d = (wr_idx_q == '0);
        out_last_d  = (wr_idx_q == LAST_IDX);
      end
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d  = '0;
        wr_bank_d = ~wr_bank_q;
        state_d   = RUN;
      end else begin
        wr_idx_d  = wr_idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wr_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      wr_bank_q   <= wr_bank_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;

endmodule
